// File: rtl/dds_freq_meter_if.sv
// ----------------------------------------------------------------------------
// dds_freq_meter_if
// Bundles the sample stream, the enable and the result handshake of the
// DDS frequency meter.
//   master : the meter (consumes en/din/meas_ready, drives the result)
//   slave  : the environment (drives en/din/meas_ready, consumes the result)
// Signals:
//   en          measurement enable
//   din         offset-binary sample, one per clock
//   f_est       recovered frequency word
//   period      clocks between the last two crossings in the gate
//   no_sig      result produced by ARM timeout
//   meas_valid  result available
//   meas_ready  consumer accepts the result
// ----------------------------------------------------------------------------
interface dds_freq_meter_if #(
    parameter int DATA_W   = 8,
    parameter int F_WORD_N = 32,
    parameter int PER_W    = 16
);
    logic                en;
    logic [DATA_W-1:0]   din;
    logic [F_WORD_N-1:0] f_est;
    logic [PER_W-1:0]    period;
    logic                no_sig;
    logic                meas_valid;
    logic                meas_ready;

    modport master (
        input  en, din, meas_ready,
        output f_est, period, no_sig, meas_valid
    );

    modport slave (
        output en, din, meas_ready,
        input  f_est, period, no_sig, meas_valid
    );
endinterface

// File: rtl/dds_freq_meter.sv
// ----------------------------------------------------------------------------
// dds_freq_meter
// Recovers the DDS frequency control word from a periodic offset-binary
// waveform. Rising midscale crossings (Schmitt trigger) are counted over a
// gate of 2^GATE_LOG2 clocks; the count shifted left by F_WORD_N-GATE_LOG2
// is the frequency word. The clock count of the last full period in the gate
// is reported alongside. Results leave through a valid/ready handshake.
// Ports:
//   clk  system clock, one sample per cycle
//   rst  asynchronous active-high reset
//   bus  dds_freq_meter_if.master (en, din, f_est, period, no_sig,
//        meas_valid, meas_ready)
// ----------------------------------------------------------------------------
module dds_freq_meter #(
    parameter int DATA_W    = 8,
    parameter int F_WORD_N  = 32,
    parameter int GATE_LOG2 = 16,
    parameter int HYST      = 4,
    parameter int PER_W     = 16
) (
    input logic              clk,
    input logic              rst,
    dds_freq_meter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} state_t;

    localparam int SHIFT = F_WORD_N - GATE_LOG2;
    localparam int MID   = 2 ** (DATA_W - 1);
    localparam logic [DATA_W-1:0]    HI_TH    = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0]    LO_TH    = DATA_W'(MID - HYST);
    localparam logic [GATE_LOG2-1:0] TMR_LAST = '1;

    state_t                state_q, state_d;
    logic                  sig_hi_q, sig_hi_d;
    logic                  sig_prev_q, sig_prev_d;
    logic [GATE_LOG2-1:0]  tmr_q, tmr_d;
    logic [GATE_LOG2:0]    xcnt_q, xcnt_d;
    logic [PER_W-1:0]      per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]      last_per_q, last_per_d;
    logic [F_WORD_N-1:0]   f_est_q, f_est_d;
    logic [PER_W-1:0]      period_q, period_d;
    logic                  no_sig_q, no_sig_d;
    logic                  valid_q, valid_d;

    logic                  xing;
    logic [PER_W-1:0]      per_inc;
    logic [GATE_LOG2:0]    xcnt_fin;

    function automatic logic [PER_W-1:0] sat_inc(input logic [PER_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        // Schmitt trigger: inside the band the previous decision is held.
        sig_hi_d = sig_hi_q;
        if (bus.din >= HI_TH) begin
            sig_hi_d = 1'b1;
        end else if (bus.din <= LO_TH) begin
            sig_hi_d = 1'b0;
        end
        sig_prev_d = sig_hi_q;
        xing       = sig_hi_q & ~sig_prev_q;

        // Period count including the current cycle, and crossing count
        // including a crossing on the current cycle (matters on the last
        // gate cycle, where the result is loaded in the same cycle).
        per_inc  = sat_inc(per_cnt_q);
        xcnt_fin = xcnt_q + {{GATE_LOG2{1'b0}}, xing};

        state_d    = state_q;
        tmr_d      = tmr_q;
        xcnt_d     = xcnt_q;
        per_cnt_d  = per_cnt_q;
        last_per_d = last_per_q;
        f_est_d    = f_est_q;
        period_d   = period_q;
        no_sig_d   = no_sig_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = ARM;
                    tmr_d   = '0;
                end
            end
            // tmr counts ARM cycles here and gate cycles in GATE.
            ARM: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (xing) begin
                    state_d    = GATE;
                    tmr_d      = '0;
                    xcnt_d     = '0;
                    per_cnt_d  = '0;
                    last_per_d = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d  = HOLD;
                    tmr_d    = '0;
                    f_est_d  = '0;
                    period_d = '0;
                    no_sig_d = 1'b1;
                    valid_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GATE: begin
                if (!bus.en) begin
                    state_d    = IDLE;
                    tmr_d      = '0;
                    xcnt_d     = '0;
                    per_cnt_d  = '0;
                    last_per_d = '0;
                end else begin
                    tmr_d     = tmr_q + 1'b1;
                    per_cnt_d = xing ? '0 : per_inc;
                    if (xing) begin
                        xcnt_d     = xcnt_fin;
                        last_per_d = per_inc;
                    end
                    if (tmr_q == TMR_LAST) begin
                        state_d  = HOLD;
                        f_est_d  = F_WORD_N'(xcnt_fin) << SHIFT;
                        period_d = xing ? per_inc : last_per_q;
                        no_sig_d = 1'b0;
                        valid_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.meas_ready) begin
                    valid_d = 1'b0;
                    tmr_d   = '0;
                    state_d = bus.en ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sig_hi_q   <= 1'b0;
            sig_prev_q <= 1'b0;
            tmr_q      <= '0;
            xcnt_q     <= '0;
            per_cnt_q  <= '0;
            last_per_q <= '0;
            f_est_q    <= '0;
            period_q   <= '0;
            no_sig_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_hi_q   <= sig_hi_d;
            sig_prev_q <= sig_prev_d;
            tmr_q      <= tmr_d;
            xcnt_q     <= xcnt_d;
            per_cnt_q  <= per_cnt_d;
            last_per_q <= last_per_d;
            f_est_q    <= f_est_d;
            period_q   <= period_d;
            no_sig_q   <= no_sig_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.f_est      = f_est_q;
    assign bus.period     = period_q;
    assign bus.no_sig     = no_sig_q;
    assign bus.meas_valid = valid_q;
endmodule

// File: tb/tb_dds_freq_meter.sv
// ----------------------------------------------------------------------------
// tb_dds_freq_meter
// Bench for dds_freq_meter with a short gate (2^10 clocks). The sample
// history is recorded per clock edge; the expected result of each
// measurement is derived from that history: Schmitt decisions, the list of
// rising-crossing edges, the first crossing after ARM entry, and the
// crossings falling inside the gate window.
// ----------------------------------------------------------------------------
module tb_dds_freq_meter;
    localparam int DATA_W    = 8;
    localparam int F_WORD_N  = 32;
    localparam int GATE_LOG2 = 10;
    localparam int HYST      = 4;
    localparam int PER_W     = 16;
    localparam int GATE      = 1 << GATE_LOG2;
    localparam int SH        = F_WORD_N - GATE_LOG2;
    localparam int MID       = 128;
    localparam int HMAX      = 65536;

    typedef struct {
        int          mode;
        logic [31:0] fctrl;
        logic [7:0]  level;
        logic [31:0] exp_f;
        longint      tol_f;
        int          exp_p;
        int          tol_p;
        bit          exp_ns;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dds_freq_meter_if #(.DATA_W(DATA_W), .F_WORD_N(F_WORD_N), .PER_W(PER_W)) bus ();

    dds_freq_meter #(
        .DATA_W(DATA_W), .F_WORD_N(F_WORD_N), .GATE_LOG2(GATE_LOG2),
        .HYST(HYST), .PER_W(PER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Waveform source: 0 constant, 1 square, 2 sine, 3 noise, 4 step 0x7C->0x84
    int          mode     = 0;
    logic [31:0] fctrl    = '0;
    logic [7:0]  level    = '0;
    int          mode_cnt = 0;
    logic [31:0] ph       = '0;

    // Sample seen by the DUT at edge k is hist[k]; cyc is the last edge index.
    int         cyc = 0;
    logic [7:0] hist [0:HMAX-1];
    int         r_edge = 1;

    logic [31:0] obs_f;
    int          obs_p;
    bit          obs_ns;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < HMAX) hist[cyc+1] <= bus.din;
    end

    initial begin
        real a;
        bus.din = '0;
        forever begin
            @(posedge clk);
            #2;
            ph = ph + fctrl;
            mode_cnt++;
            case (mode)
                1: bus.din = ph[31] ? 8'hFF : 8'h00;
                2: begin
                    a = 127.0 * $sin(6.283185307179586 * real'(ph) / 4294967296.0);
                    bus.din = 8'(128 + $rtoi($floor(a + 0.5)));
                end
                3: bus.din = 8'($urandom_range(0, 255));
                4: bus.din = (mode_cnt < 20) ? 8'h7C : 8'h84;
                default: bus.din = level;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) tol %0d", nm, act, act, exp, exp, tol);
        end
    endtask

    // Expected result of a measurement whose ARM phase starts after edge a.
    task automatic model(input int a, output int ev, output logic [31:0] ef,
                         output int ep, output bit ens);
        int xs[$];
        bit s, sp;
        int t0, n, last, prev, kmax;
        s = 1'b0;
        kmax = a + 2 * GATE + 4;
        if (kmax > cyc) kmax = cyc;
        if (kmax > HMAX - 1) kmax = HMAX - 1;
        for (int k = r_edge; k <= kmax; k++) begin
            sp = s;
            if (int'(hist[k]) >= MID + HYST) s = 1'b1;
            else if (int'(hist[k]) <= MID - HYST) s = 1'b0;
            if (s && !sp) xs.push_back(k + 1);
        end
        t0 = -1;
        foreach (xs[i]) begin
            if (t0 < 0 && xs[i] >= a + 1 && xs[i] <= a + GATE) t0 = xs[i];
        end
        if (t0 < 0) begin
            ev = a + GATE; ef = '0; ep = 0; ens = 1'b1;
        end else begin
            n = 0; last = t0; prev = t0;
            foreach (xs[i]) begin
                if (xs[i] > t0 && xs[i] <= t0 + GATE) begin
                    n++; prev = last; last = xs[i];
                end
            end
            ev  = t0 + GATE;
            ef  = 32'(n) << SH;
            ep  = (n > 0) ? (last - prev) : 0;
            ens = 1'b0;
        end
    endtask

    task automatic measure(input int a, input string nm, input int hold,
                           input bit en_after, output int h);
        int ev, ep, w, bad;
        logic [31:0] ef;
        bit ens;
        w = 0;
        while (bus.meas_valid !== 1'b1 && w < 3 * GATE) begin
            step();
            w++;
        end
        if (bus.meas_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: meas_valid=%b, required 1 within %0d cycles", nm, bus.meas_valid, 3 * GATE);
            h = cyc;
            return;
        end
        model(a, ev, ef, ep, ens);
        obs_f  = bus.f_est;
        obs_p  = int'(bus.period);
        obs_ns = bus.no_sig;
        check({nm, "_valid_edge"}, cyc, ev, 0);
        check({nm, "_f_est"}, obs_f, ef, 0);
        check({nm, "_period"}, obs_p, ep, 0);
        check({nm, "_no_sig"}, obs_ns, ens, 0);
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (bus.meas_valid !== 1'b1 || bus.f_est !== obs_f || int'(bus.period) != obs_p) bad++;
            end
            check({nm, "_hold_stable"}, bad, 0, 0);
        end
        bus.meas_ready = 1'b1;
        bus.en = en_after;
        step();
        h = cyc;
        bus.meas_ready = 1'b0;
        check({nm, "_valid_drop"}, bus.meas_valid, 0, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit use_tbl);
        int a, h;
        mode = v.mode; fctrl = v.fctrl; level = v.level; mode_cnt = 0;
        repeat (6) step();
        bus.en = 1'b1;
        a = cyc + 1;
        measure(a, nm, 0, 1'b0, h);
        if (use_tbl) begin
            check({nm, "_tbl_f"}, obs_f, v.exp_f, v.tol_f);
            check({nm, "_tbl_p"}, obs_p, v.exp_p, v.tol_p);
            check({nm, "_tbl_ns"}, obs_ns, v.exp_ns, 0);
        end
    endtask

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int a, h, bad;

        tbl[0] = '{1, 32'h0100_0000, 8'h00, 32'h0100_0000, 0, 256, 0, 1'b0};
        tbl[1] = '{2, 32'h0400_0000, 8'h00, 32'h0400_0000, 64'd4194304, 64, 1, 1'b0};
        tbl[2] = '{0, 32'h0, 8'h80, 32'h0, 0, 0, 0, 1'b1};
        tbl[3] = '{1, 32'h0040_0000, 8'h00, 32'h0040_0000, 0, 1024, 0, 1'b0};
        tbl[4] = '{4, 32'h0, 8'h00, 32'h0, 0, 0, 0, 1'b0};

        bus.en = 1'b0;
        bus.meas_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        check("reset_valid", bus.meas_valid, 0, 0);
        check("reset_f_est", bus.f_est, 0, 0);
        check("reset_period", bus.period, 0, 0);
        check("reset_no_sig", bus.no_sig, 0, 0);
        rst = 1'b0;
        r_edge = cyc + 1;
        repeat (4) step();

        for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 1'b1);

        for (int i = 0; i < 5; i++) begin
            rv.mode  = int'($urandom_range(1, 3));
            rv.fctrl = $urandom_range(32'h0040_0000, 32'h1000_0000);
            rv.level = 8'h00;
            rv.exp_f = '0; rv.tol_f = 0; rv.exp_p = 0; rv.tol_p = 0; rv.exp_ns = 1'b0;
            run_vec(rv, $sformatf("rnd%0d", i), 1'b0);
        end

        // Back-pressure: result held 1000 cycles, then a fresh measurement.
        mode = 1; fctrl = 32'h0100_0000;
        repeat (6) step();
        bus.en = 1'b1;
        a = cyc + 1;
        measure(a, "bp1", 1000, 1'b1, h);
        measure(h, "bp2", 0, 1'b0, h);
        check("bp2_f_abs", obs_f, 32'h0100_0000, 0);

        // Enable dropped in the middle of the gate.
        repeat (6) step();
        bus.en = 1'b1;
        a = cyc + 1;
        while (cyc < a + 599) step();
        bus.en = 1'b0;
        bad = 0;
        repeat (2000) begin
            step();
            if (bus.meas_valid !== 1'b0) bad++;
        end
        check("endrop_no_valid", bad, 0, 0);
        check("endrop_f_held", bus.f_est, 32'h0100_0000, 0);
        bus.en = 1'b1;
        a = cyc + 1;
        measure(a, "reen", 0, 1'b1, h);
        check("reen_f_abs", obs_f, 32'h0100_0000, 0);

        // Reset in the middle of the gate that started at the handshake.
        while (cyc < h + 699) step();
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.meas_valid, 0, 0);
        check("midrst_f_est", bus.f_est, 0, 0);
        check("midrst_period", bus.period, 0, 0);
        check("midrst_no_sig", bus.no_sig, 0, 0);
        repeat (2) step();
        rst = 1'b0;
        r_edge = cyc + 1;
        a = cyc + 1;
        measure(a, "postrst", 0, 1'b0, h);
        check("postrst_f_abs", obs_f, 32'h0100_0000, 0);
        check("postrst_p_abs", obs_p, 256, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_freq_meter.md
Name: dds_freq_meter

Overview:
- Receive-side companion to the DDS generator. Takes the DDS sample stream, or any periodic offset-binary waveform, and recovers the frequency control word that produced it.
- Detects rising midscale crossings through a Schmitt trigger, then counts them over a gate of 2^GATE_LOG2 clocks. The estimate is the crossing count shifted left by (F_WORD_N-GATE_LOG2), so no divider is needed.
- Also reports the clock count of the last full period.
- Results leave through a valid/ready handshake.

Parameters:
- DATA_W, 8, sample width; unsigned offset binary, midscale = 2^(DATA_W-1).
- F_WORD_N, 32, width of the recovered frequency word (matches the DDS accumulator width).
- GATE_LOG2, 16, gate length = 2^GATE_LOG2 clocks; must be < F_WORD_N.
- HYST, 4, hysteresis half-width in LSBs around midscale.
- PER_W, 16, width of the period counter.

Ports:
- clk  in  1  system clock; samples are valid every cycle.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  measurement enable.
- din  in  DATA_W  sample input.
- f_est  out  F_WORD_N  recovered frequency word.
- period  out  PER_W  clocks between the last two crossings in the gate.
- no_sig  out  1  set when the result was produced by ARM timeout.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, all counters 0, sig_hi=0.
- Schmitt trigger (registered):
  - sig_hi<=1 when din >= MID+HYST.
  - sig_hi<=0 when din <= MID-HYST.
  - Otherwise hold.
  - xing = sig_hi & ~sig_hi_d (one-cycle pulse).
  - Constant 2-cycle detection latency; it does not affect counts.
- States:
  - IDLE: wait for en=1 -> ARM.
  - ARM: wait for xing. That crossing's cycle is t0 -> GATE, with gate_cnt=0, xcnt=0, per_cnt=0, last_per=0. If no xing within 2^GATE_LOG2 cycles -> load f_est=0, period=0, no_sig=1 -> HOLD.
  - GATE: covers cycles t0+1 .. t0+2^GATE_LOG2 inclusive.
    - Each cycle: gate_cnt++, per_cnt++ (saturates at all-ones).
    - On xing: xcnt++, last_per<=per_cnt (value including the current cycle), per_cnt<=0.
    - A xing on the final gate cycle is counted.
    - After the final cycle: f_est <= xcnt << (F_WORD_N-GATE_LOG2), truncated to F_WORD_N bits; period <= last_per; no_sig <= 0 -> HOLD.
  - HOLD: meas_valid=1; outputs stable.
    - meas_valid & meas_ready -> meas_valid=0 next cycle. Then -> ARM if en=1, else IDLE.
    - No new measurement starts while a result is unaccepted.
- xcnt width is GATE_LOG2+1 and cannot overflow, because crossings are at least 2 cycles apart.
- Zero crossings in the gate -> f_est=0, period=0, no_sig=0.
- Exactly one crossing in the gate -> f_est = 1<<(F_WORD_N-GATE_LOG2); period = clocks from t0 to that crossing.
- en=0 during ARM or GATE: abort to IDLE next cycle, counters cleared, outputs unchanged.
- en=0 during HOLD: the result stays valid until accepted.
- rst mid-measurement: immediate return to reset values; a pending result is discarded.
- din stuck between thresholds: no crossings are generated.
- meas_valid rises exactly 1 cycle after the final gate cycle. Latency from t0 to meas_valid = 2^GATE_LOG2+1 clocks.

Test Plan:
- Square wave, 128 clks 0x00 / 128 clks 0xFF (period 256), en=1, ready=1 -> f_est=0x0100_0000 (256 crossings <<16), period=256, no_sig=0.
- Sine from the DDS model with f_ctrl=524288 (period 8192 clks) -> f_est=0x0008_0000 ±(1<<16), period=8192 ±1.
- din held at 0x80 (inside the hysteresis band) -> after 65536 ARM cycles meas_valid=1 with no_sig=1, f_est=0, period=0.
- Hold meas_ready=0 for 1000 cycles after meas_valid -> f_est and period stable, no ARM re-entry. Ready=1 -> meas_valid=0 next cycle, next result arrives after a fresh ARM+GATE.
- Period 256 square wave, drop en at gate cycle 30000 -> meas_valid stays 0, state IDLE. Re-enable -> a correct 0x0100_0000 result.
- Assert rst at gate cycle 40000 -> all outputs 0 on the same edge. Release -> normal measurement resumes.
